// File: rtl/fifo_frame_lcl_if.sv
// Handshake/status bundle between a frame producer/consumer (master) and the frame FIFO (slave).
interface fifo_frame_lcl_if #(
  parameter int DW = 64,
  parameter int AW = 5,
  parameter int LW = 16
);
  logic          den;
  logic [DW-1:0] din;
  logic          iend;
  logic          irdy;
  logic          rdrq;
  logic [DW-1:0] dout;
  logic          dv;
  logic          olast;
  logic          ordy;
  logic          flush;
  logic          empty;
  logic          full;
  logic [AW:0]   cnt;
  logic [LW-1:0] frm_len;
  logic          ovfl;
  logic          udfl;

  modport master (
    output den, din, iend, rdrq,
    input  irdy, dout, dv, olast, ordy, flush, empty, full, cnt, frm_len, ovfl, udfl
  );

  modport slave (
    input  den, din, iend, rdrq,
    output irdy, dout, dv, olast, ordy, flush, empty, full, cnt, frm_len, ovfl, udfl
  );
endinterface

// File: rtl/fifo_frame_lcl.sv
// Frame-aware FIFO: cut-through or store-and-forward, with watermark-driven
// irdy/ordy flow control, frame length capture and sticky over/underflow flags.
module fifo_frame_lcl #(
  parameter int DW     = 64,
  parameter int AW     = 5,
  parameter int LW     = 16,
  parameter int IH_LIM = 26,
  parameter int IL_LIM = 16,
  parameter int OH_LIM = 16,
  parameter int OL_LIM = 4,
  parameter int SF     = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  fifo_frame_lcl_if.slave bus
);
  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_IH    = (AW+1)'(IH_LIM);
  localparam logic [AW:0] C_IL    = (AW+1)'(IL_LIM);
  localparam logic [AW:0] C_OH    = (AW+1)'(OH_LIM);
  localparam logic [AW:0] C_OL    = (AW+1)'(OL_LIM);

  logic [DW-1:0] r_mem [0:DEPTH-1];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_cnt;
  logic [LW-1:0] r_icnt, r_ocnt, r_frm_len;
  logic [DW-1:0] r_dout;
  logic          r_dv, r_flush, r_ovfl, r_udfl, r_irdy, r_ordy;

  logic w_kill, w_empty, w_full, w_wr, w_rd, w_olast, w_irdy, w_ordy;

  // Access qualification and combinational flow-control outputs
  always_comb begin
    w_kill  = rst | clr;
    w_empty = (r_cnt == '0);
    w_full  = (r_cnt == C_DEPTH);
    w_wr    = bus.den  & ~w_full  & ~w_kill;
    w_rd    = bus.rdrq & ~w_empty & ~w_kill;
    w_olast = w_rd & r_flush & (r_ocnt == (r_icnt - LW'(1)));

    // Watermark hysteresis: between the limits the previous decision is held.
    w_irdy = r_irdy;
    if (w_kill)                    w_irdy = 1'b0;
    else if (r_flush | bus.iend)   w_irdy = 1'b0;
    else if (r_cnt <= C_IL)        w_irdy = 1'b1;
    else if (r_cnt >= C_IH)        w_irdy = 1'b0;

    w_ordy = r_ordy;
    if (w_kill)                    w_ordy = 1'b0;
    else if (r_flush)              w_ordy = ~w_olast;
    else if (SF != 0)              w_ordy = 1'b0;
    else if (r_cnt <= C_OL)        w_ordy = 1'b0;
    else if (r_cnt >= C_OH)        w_ordy = 1'b1;
  end

  // Storage array: data only, never cleared
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= bus.din;
  end

  // Pointer, occupancy, frame and status registers
  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_icnt    <= '0;
      r_ocnt    <= '0;
      r_frm_len <= '0;
      r_dout    <= '0;
      r_dv      <= 1'b0;
      r_flush   <= 1'b0;
      r_ovfl    <= 1'b0;
      r_udfl    <= 1'b0;
      r_irdy    <= 1'b0;
      r_ordy    <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) begin
        r_rptr <= r_rptr + AW'(1);
        r_dout <= r_mem[r_rptr];
      end
      r_cnt  <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
      r_dv   <= w_rd;
      if (bus.den & w_full)   r_ovfl <= 1'b1;
      if (bus.rdrq & w_empty) r_udfl <= 1'b1;

      if (w_olast) begin
        r_icnt <= '0;
        r_ocnt <= '0;
      end else begin
        r_icnt <= r_icnt + LW'(w_wr);
        r_ocnt <= r_ocnt + LW'(w_rd);
      end

      // A write landing in the iend cycle still belongs to the closing frame.
      if (w_olast) begin
        r_flush <= 1'b0;
      end else if (bus.iend & ~r_flush) begin
        r_flush   <= 1'b1;
        r_frm_len <= r_icnt + LW'(w_wr);
      end

      r_irdy <= w_irdy;
      r_ordy <= w_ordy;
    end
  end

  assign bus.irdy    = w_irdy;
  assign bus.ordy    = w_ordy;
  assign bus.olast   = w_olast;
  assign bus.dout    = r_dout;
  assign bus.dv      = r_dv;
  assign bus.flush   = r_flush;
  assign bus.empty   = w_empty;
  assign bus.full    = w_full;
  assign bus.cnt     = r_cnt;
  assign bus.frm_len = r_frm_len;
  assign bus.ovfl    = r_ovfl;
  assign bus.udfl    = r_udfl;
endmodule

// File: tb/tb_fifo_frame_lcl.sv
// Directed bench for fifo_frame_lcl: vector table plus hand-written frame, full,
// clear and store-and-forward sequences on a cut-through and a store-and-forward instance.
module tb_fifo_frame_lcl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  fifo_frame_lcl_if #(.DW(64), .AW(5), .LW(16)) b0 ();
  fifo_frame_lcl_if #(.DW(64), .AW(5), .LW(16)) b1 ();

  fifo_frame_lcl #(.DW(64), .AW(5), .LW(16), .SF(0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .bus(b0));
  fifo_frame_lcl #(.DW(64), .AW(5), .LW(16), .SF(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .bus(b1));

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        den;
    logic [63:0] din;
    logic        rdrq;
    logic [5:0]  e_cnt;
    logic        e_dv;
    logic [63:0] e_dout;
    logic        e_empty;
    logic        e_udfl;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    b0.den = 1'b0; b0.din = '0; b0.iend = 1'b0; b0.rdrq = 1'b0;
    b1.den = 1'b0; b1.din = '0; b1.iend = 1'b0; b1.rdrq = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    clr = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    idle_in();
    tbl[0]  = '{1'b0, 64'h0,  1'b1, 6'd0, 1'b0, 64'h0,  1'b1, 1'b0};
    tbl[1]  = '{1'b0, 64'h0,  1'b0, 6'd0, 1'b0, 64'h0,  1'b1, 1'b1};
    tbl[2]  = '{1'b1, 64'hA1, 1'b0, 6'd0, 1'b0, 64'h0,  1'b1, 1'b1};
    tbl[3]  = '{1'b1, 64'hA2, 1'b0, 6'd1, 1'b0, 64'h0,  1'b0, 1'b1};
    tbl[4]  = '{1'b1, 64'hA3, 1'b0, 6'd2, 1'b0, 64'h0,  1'b0, 1'b1};
    tbl[5]  = '{1'b1, 64'hA4, 1'b0, 6'd3, 1'b0, 64'h0,  1'b0, 1'b1};
    tbl[6]  = '{1'b1, 64'hA5, 1'b0, 6'd4, 1'b0, 64'h0,  1'b0, 1'b1};
    tbl[7]  = '{1'b1, 64'hA6, 1'b1, 6'd5, 1'b0, 64'h0,  1'b0, 1'b1};
    tbl[8]  = '{1'b0, 64'h0,  1'b0, 6'd5, 1'b1, 64'hA1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 64'h0,  1'b1, 6'd5, 1'b0, 64'h0,  1'b0, 1'b1};
    tbl[10] = '{1'b0, 64'h0,  1'b0, 6'd4, 1'b1, 64'hA2, 1'b0, 1'b1};

    // Reset state while rst is still asserted
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cnt",   b0.cnt, 0);
    chk("rst_empty", b0.empty, 1);
    chk("rst_full",  b0.full, 0);
    chk("rst_irdy",  b0.irdy, 0);
    chk("rst_ordy",  b0.ordy, 0);
    chk("rst_dv",    b0.dv, 0);
    chk("rst_dout",  b0.dout, 0);
    chk("rst_flush", b0.flush, 0);
    chk("rst_olast", b0.olast, 0);
    chk("rst_flen",  b0.frm_len, 0);
    chk("rst_ovfl",  b0.ovfl, 0);
    chk("rst_udfl",  b0.udfl, 0);

    // 20 writes: irdy up right after reset, ordy rises at cnt 16
    do_reset();
    #1;
    chk("w20_irdy_after_rst", b0.irdy, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      b0.den = 1'b1; b0.din = 64'(100 + i);
      #1;
      chk($sformatf("w20_ordy_%0d", i), b0.ordy, (i >= 16));
      chk($sformatf("w20_irdy_%0d", i), b0.irdy, 1);
    end
    @(negedge clk);
    b0.den = 1'b0;
    #1;
    chk("w20_cnt",  b0.cnt, 20);
    chk("w20_ordy", b0.ordy, 1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      b0.rdrq = 1'b1;
      #1;
      if (k > 0) begin
        chk($sformatf("w20_dv_%0d", k), b0.dv, 1);
        chk($sformatf("w20_dout_%0d", k), b0.dout, 64'(100 + k - 1));
      end
    end
    @(negedge clk);
    b0.rdrq = 1'b0;
    #1;
    chk("w20_last_dout", b0.dout, 119);
    chk("w20_drain_cnt", b0.cnt, 0);
    @(negedge clk);
    #1;
    chk("w20_dv_idle", b0.dv, 0);

    // Vector table: underflow, fill, simultaneous read/write at cnt 5
    do_reset();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      b0.den = tbl[i].den; b0.din = tbl[i].din; b0.rdrq = tbl[i].rdrq;
      #1;
      chk($sformatf("tbl%0d_cnt", i),   b0.cnt,   tbl[i].e_cnt);
      chk($sformatf("tbl%0d_dv", i),    b0.dv,    tbl[i].e_dv);
      chk($sformatf("tbl%0d_empty", i), b0.empty, tbl[i].e_empty);
      chk($sformatf("tbl%0d_udfl", i),  b0.udfl,  tbl[i].e_udfl);
      if (tbl[i].e_dv) chk($sformatf("tbl%0d_dout", i), b0.dout, tbl[i].e_dout);
    end
    idle_in();

    // 40 back-to-back writes into 32 entries
    do_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      b0.den = 1'b1; b0.din = 64'(i);
      #1;
      chk($sformatf("ovf_cnt_%0d", i),  b0.cnt,  (i < 32) ? i : 32);
      chk($sformatf("ovf_irdy_%0d", i), b0.irdy, (((i < 32) ? i : 32) < 26));
      chk($sformatf("ovf_full_%0d", i), b0.full, (i >= 32));
      chk($sformatf("ovf_ovfl_%0d", i), b0.ovfl, (i >= 33));
    end
    @(negedge clk);
    b0.den = 1'b0;
    #1;
    chk("ovf_cnt_end",  b0.cnt, 32);
    chk("ovf_ovfl_end", b0.ovfl, 1);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      b0.rdrq = 1'b1;
      #1;
      if (k > 0) chk($sformatf("ovf_dout_%0d", k), b0.dout, 64'(k - 1));
    end
    @(negedge clk);
    b0.rdrq = 1'b0;
    #1;
    chk("ovf_last_dout", b0.dout, 31);
    chk("ovf_empty",     b0.empty, 1);

    // 10-word frame, iend with the 10th write, then a 3-word frame
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      b0.den = 1'b1; b0.din = 64'(200 + i); b0.iend = (i == 9);
      #1;
      chk($sformatf("frm_irdy_%0d", i), b0.irdy, (i != 9));
    end
    @(negedge clk);
    b0.den = 1'b0; b0.iend = 1'b0;
    #1;
    chk("frm_flush", b0.flush, 1);
    chk("frm_len",   b0.frm_len, 10);
    chk("frm_ordy",  b0.ordy, 1);
    chk("frm_cnt",   b0.cnt, 10);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      b0.rdrq = 1'b1;
      #1;
      chk($sformatf("frm_olast_%0d", k), b0.olast, (k == 9));
      chk($sformatf("frm_ordy_%0d", k),  b0.ordy,  (k != 9));
      if (k > 0) chk($sformatf("frm_dout_%0d", k), b0.dout, 64'(200 + k - 1));
    end
    @(negedge clk);
    b0.rdrq = 1'b0;
    #1;
    chk("frm_end_flush", b0.flush, 0);
    chk("frm_end_ordy",  b0.ordy, 0);
    chk("frm_end_olast", b0.olast, 0);
    chk("frm_end_dout",  b0.dout, 209);
    chk("frm_end_cnt",   b0.cnt, 0);
    chk("frm_end_len",   b0.frm_len, 10);
    chk("frm_end_irdy",  b0.irdy, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b0.den = 1'b1; b0.din = 64'(300 + i); b0.iend = (i == 2);
    end
    @(negedge clk);
    b0.den = 1'b0; b0.iend = 1'b0;
    #1;
    chk("frm2_len",   b0.frm_len, 3);
    chk("frm2_flush", b0.flush, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      b0.rdrq = 1'b1;
      #1;
      chk($sformatf("frm2_olast_%0d", k), b0.olast, (k == 2));
    end
    @(negedge clk);
    b0.rdrq = 1'b0;
    #1;
    chk("frm2_end_flush", b0.flush, 0);
    chk("frm2_end_dout",  b0.dout, 302);

    // Soft clear mid-frame at cnt 12
    do_reset();
    @(negedge clk);
    b0.rdrq = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      b0.rdrq = 1'b0; b0.den = 1'b1; b0.din = 64'(400 + i); b0.iend = (i == 12);
    end
    @(negedge clk);
    b0.den = 1'b0; b0.iend = 1'b0; b0.rdrq = 1'b1;
    @(negedge clk);
    b0.rdrq = 1'b0;
    #1;
    chk("clr_pre_cnt",  b0.cnt, 12);
    chk("clr_pre_dout", b0.dout, 400);
    chk("clr_pre_udfl", b0.udfl, 1);
    chk("clr_pre_len",  b0.frm_len, 13);
    chk("clr_pre_flsh", b0.flush, 1);
    @(negedge clk);
    clr = 1'b1; b0.rdrq = 1'b1;
    #1;
    chk("clr_irdy_now", b0.irdy, 0);
    chk("clr_ordy_now", b0.ordy, 0);
    @(negedge clk);
    clr = 1'b0; b0.rdrq = 1'b0;
    #1;
    chk("clr_cnt",   b0.cnt, 0);
    chk("clr_empty", b0.empty, 1);
    chk("clr_udfl",  b0.udfl, 0);
    chk("clr_ovfl",  b0.ovfl, 0);
    chk("clr_flush", b0.flush, 0);
    chk("clr_len",   b0.frm_len, 0);
    chk("clr_dv",    b0.dv, 0);
    chk("clr_dout",  b0.dout, 0);
    chk("clr_irdy",  b0.irdy, 1);
    chk("clr_ordy",  b0.ordy, 0);
    b0.den = 1'b1; b0.din = 64'hBEEF;
    @(negedge clk);
    b0.den = 1'b0; b0.rdrq = 1'b1;
    @(negedge clk);
    b0.rdrq = 1'b0;
    #1;
    chk("clr_new_dv",   b0.dv, 1);
    chk("clr_new_dout", b0.dout, 64'hBEEF);

    // Store-and-forward instance: ordy only once the frame is closed
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      b1.den = 1'b1; b1.din = 64'(500 + i);
      #1;
      if (i >= 16) chk($sformatf("sf_ordy_%0d", i), b1.ordy, 0);
    end
    @(negedge clk);
    b1.den = 1'b0; b1.iend = 1'b1;
    #1;
    chk("sf_cnt",       b1.cnt, 20);
    chk("sf_ordy_iend", b1.ordy, 0);
    @(negedge clk);
    b1.iend = 1'b0;
    #1;
    chk("sf_ordy_after", b1.ordy, 1);
    chk("sf_flush",      b1.flush, 1);
    chk("sf_len",        b1.frm_len, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_frame_lcl.md
FIFO_FRAME_LCL -- requirements
Module: fifo_frame_lcl

Interface
REQ-001 SHALL have parameter DW, default 64, data width in bits.
REQ-002 SHALL have parameter AW, default 5, address width; DEPTH = 2^AW entries.
REQ-003 SHALL have parameter LW, default 16, frame-counter width.
REQ-004 SHALL have parameters IH_LIM/IL_LIM/OH_LIM/OL_LIM, defaults 26/16/16/4, occupancy watermarks.
REQ-005 SHALL have parameter SF, default 0, mode: 0 cut-through, 1 store-and-forward.
REQ-006 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port clr  in  1  synchronous soft clear.
REQ-009 SHALL have ports den in 1 write strobe, din in DW write data, iend in 1 last input word marker.
REQ-010 SHALL have port irdy  out  1  input may continue.
REQ-011 SHALL have ports rdrq in 1 read request, dout out DW read data, dv out 1 dout valid.
REQ-012 SHALL have ports olast out 1, ordy out 1, flush out 1, empty out 1, full out 1.
REQ-013 SHALL have ports cnt out AW+1 occupancy, frm_len out LW frame length, ovfl out 1, udfl out 1.

Function
REQ-014 SHALL use internal DEPTH x DW storage with binary pointers; no vendor FIFO.
REQ-015 SHALL accept a write on den & ~full and a read on rdrq & ~empty; full/empty come from registered cnt (full: cnt==DEPTH; empty: cnt==0).
REQ-016 SHALL drop writes when full and set ovfl (sticky); rejected reads when empty set udfl (sticky); pointers unchanged.
REQ-017 SHALL register dout and assert dv for exactly one cycle, the cycle after each accepted read; dv=0 otherwise.
REQ-018 SHALL update cnt the cycle after the access: +1 write only, -1 read only, unchanged on both or neither.
REQ-019 SHALL keep LW-bit counters i_cnt (accepted writes) and o_cnt (accepted reads), wrapping mod 2^LW.
REQ-020 SHALL set flush the cycle after iend, clear it the cycle after olast; iend while flush=1 ignored.
REQ-021 SHALL count a write accepted in the iend cycle in the frame.
REQ-022 SHALL drive olast combinationally = rdrq & ~empty & flush & (o_cnt == i_cnt-1 mod 2^LW).
REQ-023 SHALL clear i_cnt and o_cnt the cycle after olast.
REQ-024 SHALL load frm_len with the frame word count in the cycle flush rises; hold until next load, clr, or rst.
REQ-025 SHALL drive irdy, priority order: clr->0; flush|iend->0; cnt<=IL_LIM->1; cnt>=IH_LIM->0; else hold.
REQ-026 SHALL drive ordy, priority: clr->0; flush->~olast; SF=1->0; cnt<=OL_LIM->0; cnt>=OH_LIM->1; else hold.
REQ-027 SHALL require IL_LIM<IH_LIM<=DEPTH and OL_LIM<OH_LIM<=DEPTH; frames >= 2^LW words unsupported.
REQ-028 SHALL give clr the same effect as rst on all state and outputs; rst has priority.

Reset
REQ-029 SHALL on rst: pointers, cnt, i_cnt, o_cnt, frm_len=0; irdy, ordy, flush, dv, ovfl, udfl, olast=0; empty=1, full=0; dout=0.
REQ-030 SHALL honour rst or clr mid-frame: in-flight data discarded, irdy reasserts the following cycle (cnt=0<=IL_LIM).

Verification
REQ-031 SHALL cover: rst, then 20 writes -> irdy=1 from cycle after rst, cnt=20, ordy=1 once cnt>=16 (SF=0).
REQ-032 SHALL cover: 40 back-to-back writes (DEPTH 32) -> irdy=0 at cnt>=26, 33rd write dropped, ovfl=1, cnt=32.
REQ-033 SHALL cover: 10-word frame, iend with 10th den -> flush=1, frm_len=10; 10 reads give olast on 10th, ordy and flush 0 next cycle.
REQ-034 SHALL cover: rdrq when empty -> udfl=1, dv=0, cnt=0; simultaneous den&rdrq at cnt=5 -> cnt stays 5, dv=1.
REQ-035 SHALL cover: SF=1, 20 writes without iend -> ordy=0; iend -> ordy=1 next cycle.
REQ-036 SHALL cover: clr at cnt=12 mid-frame -> all state zeroed next cycle, ovfl/udfl cleared.
